// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB transfer/burst encodings and helpers for the arbiter slice.
package ahb_arbiter_pkg;

    localparam int HMASTER_W   = 4;
    localparam int MAX_MASTERS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    // Beats remaining after the NONSEQ; undefined-length bursts never hold the bus.
    function automatic logic [3:0] burst_beats(input hburst_e burst);
        logic [3:0] beats;
        beats = 4'd0;
        case (burst)
            WRAP4,  INCR4:  beats = 4'd3;
            WRAP8,  INCR8:  beats = 4'd7;
            WRAP16, INCR16: beats = 4'd15;
            default:        beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Request/grant bundle between the master agents and the arbiter.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
) ();
    import ahb_arbiter_pkg::*;

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    htrans_e                htrans;
    hburst_e                hburst;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [HMASTER_W-1:0]   hmaster;
    logic                   hmastlock;

    // The arbiter is the slave side of this bundle.
    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );

endinterface

// File: rtl/ahb_arb_prio_enc.sv
// Fixed-priority request picker: lowest requesting index wins, default when idle.
module ahb_arb_prio_enc
    import ahb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic [NUM_MASTERS-1:0] hbusreq,
    output logic [HMASTER_W-1:0]   winner,
    output logic [NUM_MASTERS-1:0] winner_oh
);

    // Scan from the top so the lowest set index is the last to overwrite.
    always_comb begin
        winner = HMASTER_W'(DEFAULT_MASTER);
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (hbusreq[i]) begin
                winner = HMASTER_W'(i);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_oh
        assign winner_oh[gi] = (winner == HMASTER_W'(gi));
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB fixed-priority arbiter: holds the grant through fixed-length bursts and locked sequences.
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    ahb_arbiter_if.slave bus
);

    localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] hgrant_reg;
    logic [NUM_MASTERS-1:0] hgrant_next;
    logic [HMASTER_W-1:0]   hmaster_reg;
    logic [3:0]             beats_left_reg;
    logic [3:0]             beats_left_next;
    logic [HMASTER_W-1:0]   gidx;
    logic [HMASTER_W-1:0]   winner;
    logic [NUM_MASTERS-1:0] winner_oh;
    logic                   locked;
    logic                   seq_accepted;
    logic                   arb_open;

    ahb_arb_prio_enc #(
        .NUM_MASTERS   (NUM_MASTERS),
        .DEFAULT_MASTER(DEFAULT_MASTER)
    ) u_prio_enc (
        .hbusreq  (bus.hbusreq),
        .winner   (winner),
        .winner_oh(winner_oh)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_reg[i]) begin
                gidx = HMASTER_W'(i);
            end
        end
    end

    // hgrant is one-hot, so masking avoids a variable-width index into hlock.
    assign locked       = |(bus.hlock & hgrant_reg);
    assign seq_accepted = bus.hready && (bus.htrans == SEQ);
    assign arb_open     = !locked &&
                          ((beats_left_reg == 4'd0) ||
                           ((beats_left_reg == 4'd1) && seq_accepted));

    always_comb begin
        beats_left_next = beats_left_reg;
        if (bus.hready) begin
            case (bus.htrans)
                NONSEQ:  beats_left_next = burst_beats(bus.hburst);
                SEQ:     if (beats_left_reg != 4'd0) beats_left_next = beats_left_reg - 4'd1;
                IDLE:    beats_left_next = 4'd0;
                default: beats_left_next = beats_left_reg;
            endcase
        end
    end

    always_comb begin
        hgrant_next = hgrant_reg;
        if (arb_open && (winner != gidx)) begin
            hgrant_next = winner_oh;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hgrant_reg     <= GRANT_RST;
            hmaster_reg    <= HMASTER_W'(DEFAULT_MASTER);
            beats_left_reg <= 4'd0;
        end else begin
            hgrant_reg     <= hgrant_next;
            beats_left_reg <= beats_left_next;
            if (bus.hready) begin
                hmaster_reg <= gidx;
            end
        end
    end

    assign bus.hgrant    = hgrant_reg;
    assign bus.hmaster   = hmaster_reg;
    assign bus.hmastlock = locked;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: priority, burst hold, wait states, lock, async reset.
module tb_ahb_arbiter;
    import ahb_arbiter_pkg::*;

    localparam int N = 4;

    logic hclk   = 1'b0;
    logic hreset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 hclk = ~hclk;

    ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(0)
    ) dut (
        .hclk  (hclk),
        .hreset(hreset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot_idx(input logic [N-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock,
                         input htrans_e tr, input hburst_e bu, input logic rdy);
        bus.hbusreq = req;
        bus.hlock   = lock;
        bus.htrans  = tr;
        bus.hburst  = bu;
        bus.hready  = rdy;
        $display("drive t=%0t req=%b lock=%b htrans=%s hburst=%s hready=%b",
                 $time, req, lock, tr.name(), bu.name(), rdy);
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Continuous properties checked every cycle on the falling edge.
    logic       nbm_valid = 1'b0;
    logic [3:0] nbm_exp   = 4'd0;

    always @(posedge hclk) begin
        nbm_valid = !hreset && bus.hready;
        nbm_exp   = onehot_idx(bus.hgrant);
    end

    always @(negedge hclk) begin
        if (nbm_valid && !hreset) begin
            check("NEXT_BUS_MASTER", 32'(bus.hmaster), 32'(nbm_exp));
        end
        check("HMASTLOCK_TIMING", 32'(bus.hmastlock), 32'(|(bus.hlock & bus.hgrant)));
        check("HGRANT_ONEHOT", 32'($onehot(bus.hgrant)), 32'd1);
    end

    initial begin
        drive(4'b0000, 4'b0001, IDLE, SINGLE, 1'b1);

        // 1: reset / default master
        step();
        check("rst_hgrant", 32'(bus.hgrant), 32'h1);
        check("rst_hmaster", 32'(bus.hmaster), 32'h0);
        check("rst_hmastlock_on", 32'(bus.hmastlock), 32'h1);
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        #1;
        check("rst_hmastlock_off", 32'(bus.hmastlock), 32'h0);
        hreset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_hgrant", 32'(bus.hgrant), 32'h1);
            check("idle_hmaster", 32'(bus.hmaster), 32'h0);
        end

        // 2: priority
        drive(4'b1010, 4'b0000, IDLE, SINGLE, 1'b1);
        step();
        check("prio_hgrant", 32'(bus.hgrant), 32'h2);
        check("prio_hmaster_old", 32'(bus.hmaster), 32'h0);
        step();
        check("prio_hmaster_new", 32'(bus.hmaster), 32'h1);
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        step();
        check("prio_back_hgrant", 32'(bus.hgrant), 32'h1);
        step();
        check("prio_back_hmaster", 32'(bus.hmaster), 32'h0);

        // 4: wait states stall hmaster
        drive(4'b1010, 4'b0000, IDLE, SINGLE, 1'b0);
        step();
        check("wait_hgrant", 32'(bus.hgrant), 32'h2);
        check("wait_hmaster_0", 32'(bus.hmaster), 32'h0);
        step();
        check("wait_hmaster_1", 32'(bus.hmaster), 32'h0);
        step();
        check("wait_hmaster_2", 32'(bus.hmaster), 32'h0);
        drive(4'b1010, 4'b0000, IDLE, SINGLE, 1'b1);
        step();
        check("wait_hmaster_rdy", 32'(bus.hmaster), 32'h1);
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        step();
        step();
        check("wait_back_hmaster", 32'(bus.hmaster), 32'h0);

        // 3: burst hold with a higher-priority request mid-burst
        drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        step();
        check("burst_grant_m2", 32'(bus.hgrant), 32'h4);
        step();
        check("burst_hmaster_m2", 32'(bus.hmaster), 32'h2);
        drive(4'b0100, 4'b0000, NONSEQ, INCR4, 1'b1);
        step();
        check("burst_nonseq_hgrant", 32'(bus.hgrant), 32'h4);
        check("burst_nonseq_beats", 32'(dut.beats_left_reg), 32'h3);
        drive(4'b0100, 4'b0000, SEQ, INCR4, 1'b1);
        step();
        check("burst_seq1_hgrant", 32'(bus.hgrant), 32'h4);
        check("burst_seq1_beats", 32'(dut.beats_left_reg), 32'h2);
        drive(4'b0101, 4'b0000, SEQ, INCR4, 1'b1);
        step();
        check("burst_seq2_hgrant", 32'(bus.hgrant), 32'h4);
        check("burst_seq2_beats", 32'(dut.beats_left_reg), 32'h1);
        drive(4'b0101, 4'b0000, SEQ, INCR4, 1'b1);
        step();
        check("burst_last_hgrant", 32'(bus.hgrant), 32'h1);
        check("burst_last_beats", 32'(dut.beats_left_reg), 32'h0);
        check("burst_last_hmaster", 32'(bus.hmaster), 32'h2);
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        step();
        check("burst_after_hmaster", 32'(bus.hmaster), 32'h0);

        // 5: locked sequence blocks higher-priority requests
        drive(4'b1000, 4'b1000, IDLE, SINGLE, 1'b1);
        step();
        check("lock_hgrant", 32'(bus.hgrant), 32'h8);
        check("lock_hmastlock", 32'(bus.hmastlock), 32'h1);
        drive(4'b1111, 4'b1000, IDLE, SINGLE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lock_hold_hgrant", 32'(bus.hgrant), 32'h8);
            check("lock_hold_hmastlock", 32'(bus.hmastlock), 32'h1);
        end
        drive(4'b1111, 4'b0000, IDLE, SINGLE, 1'b1);
        #1;
        check("lock_drop_hmastlock", 32'(bus.hmastlock), 32'h0);
        check("lock_drop_hgrant", 32'(bus.hgrant), 32'h8);
        step();
        check("lock_release_hgrant", 32'(bus.hgrant), 32'h1);
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        step();
        step();

        // 6: async reset in beat 2 of a locked INCR8
        drive(4'b0100, 4'b0100, IDLE, SINGLE, 1'b1);
        step();
        step();
        check("arst_pre_hmaster", 32'(bus.hmaster), 32'h2);
        drive(4'b0100, 4'b0100, NONSEQ, INCR8, 1'b1);
        step();
        drive(4'b0100, 4'b0100, SEQ, INCR8, 1'b1);
        step();
        check("arst_pre_beats", 32'(dut.beats_left_reg), 32'h6);
        #2;
        hreset = 1'b1;
        #1;
        check("arst_hgrant", 32'(bus.hgrant), 32'h1);
        check("arst_hmaster", 32'(bus.hmaster), 32'h0);
        check("arst_beats", 32'(dut.beats_left_reg), 32'h0);
        check("arst_hmastlock", 32'(bus.hmastlock), 32'h0);
        step();
        hreset = 1'b0;
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        step();
        check("arst_after_hgrant", 32'(bus.hgrant), 32'h1);
        check("arst_after_hmaster", 32'(bus.hmaster), 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
